// File: rtl/c16_kbd_pkg.sv
// Shared types, scancode constants and C16 matrix positions for the PS/2 keyboard front end.
package c16_kbd_pkg;

    typedef logic [2:0] mcol_t;
    typedef logic [2:0] mrow_t;

    typedef struct packed {
        mcol_t col;
        mrow_t row;
    } key_pos_t;

    typedef struct packed {
        logic  valid;
        mcol_t col;
        mrow_t row;
    } keymap_ent_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam logic [7:0] SC_RELEASE = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;
    localparam logic [7:0] SC_F12     = 8'h07;

    localparam key_pos_t KEY_RETURN = '{col: 3'd0, row: 3'd1};
    localparam key_pos_t KEY_A      = '{col: 3'd1, row: 3'd2};
    localparam key_pos_t KEY_SHIFT  = '{col: 3'd1, row: 3'd7};
    localparam key_pos_t KEY_SPACE  = '{col: 3'd7, row: 3'd4};

    function automatic keymap_ent_t mk_ent(input int c, input int r);
        return '{valid: 1'b1, col: 3'(c), row: 3'(r)};
    endfunction

    function automatic keymap_ent_t pos_ent(input key_pos_t p);
        return '{valid: 1'b1, col: p.col, row: p.row};
    endfunction

endpackage

// File: rtl/c16_ps2_keymap.sv
// Set-2 scancode {ext, code} to C16 matrix position lookup.
// Latency: purely combinational.
// Backpressure: none, evaluated every cycle.
module c16_ps2_keymap
    import c16_kbd_pkg::*;
(
    input  logic        ext,
    input  logic [7:0]  code,
    output keymap_ent_t entry
);

    always_comb begin
        entry = '0;
        case ({ext, code})
            9'h05A: entry = pos_ent(KEY_RETURN);
            9'h01C: entry = pos_ent(KEY_A);
            9'h012: entry = pos_ent(KEY_SHIFT);
            9'h059: entry = pos_ent(KEY_SHIFT);
            9'h029: entry = pos_ent(KEY_SPACE);
            9'h066: entry = mk_ent(0, 0);   9'h005: entry = mk_ent(0, 4);
            9'h006: entry = mk_ent(0, 5);   9'h004: entry = mk_ent(0, 6);
            9'h026: entry = mk_ent(1, 0);   9'h01D: entry = mk_ent(1, 1);
            9'h025: entry = mk_ent(1, 3);   9'h01A: entry = mk_ent(1, 4);
            9'h01B: entry = mk_ent(1, 5);   9'h024: entry = mk_ent(1, 6);
            9'h02E: entry = mk_ent(2, 0);   9'h02D: entry = mk_ent(2, 1);
            9'h023: entry = mk_ent(2, 2);   9'h036: entry = mk_ent(2, 3);
            9'h021: entry = mk_ent(2, 4);   9'h02B: entry = mk_ent(2, 5);
            9'h02C: entry = mk_ent(2, 6);   9'h022: entry = mk_ent(2, 7);
            9'h03D: entry = mk_ent(3, 0);   9'h035: entry = mk_ent(3, 1);
            9'h034: entry = mk_ent(3, 2);   9'h03E: entry = mk_ent(3, 3);
            9'h032: entry = mk_ent(3, 4);   9'h033: entry = mk_ent(3, 5);
            9'h03C: entry = mk_ent(3, 6);   9'h02A: entry = mk_ent(3, 7);
            9'h046: entry = mk_ent(4, 0);   9'h043: entry = mk_ent(4, 1);
            9'h03B: entry = mk_ent(4, 2);   9'h045: entry = mk_ent(4, 3);
            9'h03A: entry = mk_ent(4, 4);   9'h042: entry = mk_ent(4, 5);
            9'h044: entry = mk_ent(4, 6);   9'h031: entry = mk_ent(4, 7);
            9'h172: entry = mk_ent(5, 0);   9'h04D: entry = mk_ent(5, 1);
            9'h04B: entry = mk_ent(5, 2);   9'h175: entry = mk_ent(5, 3);
            9'h049: entry = mk_ent(5, 4);   9'h04C: entry = mk_ent(5, 5);
            9'h04E: entry = mk_ent(5, 6);   9'h041: entry = mk_ent(5, 7);
            9'h16B: entry = mk_ent(6, 0);   9'h174: entry = mk_ent(6, 3);
            9'h076: entry = mk_ent(6, 4);   9'h055: entry = mk_ent(6, 5);
            9'h04A: entry = mk_ent(6, 7);
            9'h016: entry = mk_ent(7, 0);   9'h16C: entry = mk_ent(7, 1);
            9'h014: entry = mk_ent(7, 2);   9'h01E: entry = mk_ent(7, 3);
            9'h011: entry = mk_ent(7, 5);   9'h015: entry = mk_ent(7, 6);
            9'h00D: entry = mk_ent(7, 7);
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/c16_ps2_keymatrix.sv
// PS/2 receiver, set-2 decoder and C16 key-matrix image with TED row read-back.
// Latency: byte decoded the cycle after the stop sample; row_n registered one cycle after matrix/select.
// Backpressure: none, the PS/2 device cannot be stalled; every accepted byte is consumed immediately.
module c16_ps2_keymatrix
    import c16_kbd_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 28000000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] col_sel_n,
    output logic [7:0] row_n,
    output logic       key_strobe,
    output logic       sysreset_req,
    output logic       frame_err
);

    localparam int unsigned TO_CYC = CLK_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned TO_W   = $clog2(TO_CYC + 1);
    localparam int unsigned FLT_W  = $clog2(FILTER_LEN + 1);

    logic [1:0]       clk_sync, dat_sync;
    logic             clk_filt, flt_flip, fall;
    logic [FLT_W-1:0] flt_cnt;

    rx_state_t        state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d, byte_q;
    logic             par_q, par_d, byte_vld_q, byte_vld_d, err_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

    logic [7:0][7:0]  matrix_q;
    logic             rel_q, ext_q;
    logic [7:0]       row_hit;
    keymap_ent_t      ent;

    // A level change is only believed after FILTER_LEN identical samples.
    assign flt_flip = (clk_sync[1] != clk_filt) && (flt_cnt == FLT_W'(FILTER_LEN - 1));
    assign fall     = flt_flip && clk_filt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_dat};
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_flip) begin
                flt_cnt  <= '0;
                clk_filt <= clk_sync[1];
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;
        to_cnt_d   = (state_q == RX_IDLE || fall) ? '0 : to_cnt_q + 1'b1;
        if (state_q != RX_IDLE && to_cnt_q == TO_W'(TO_CYC)) begin
            state_d  = RX_IDLE;
            err_d    = 1'b1;
            to_cnt_d = '0;
        end else if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    // A high data line at a falling edge is not a start bit: ignore silently.
                    if (!dat_sync[1]) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                        par_d     = 1'b0;
                    end
                end
                RX_DATA: begin
                    shift_d   = {dat_sync[1], shift_q[7:1]};
                    par_d     = par_q ^ dat_sync[1];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
                    par_d   = par_q ^ dat_sync[1];
                    state_d = RX_STOP;
                end
                default: begin
                    state_d = RX_IDLE;
                    if (dat_sync[1] && par_q) byte_vld_d = 1'b1;
                    else                      err_d      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= RX_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            frame_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            byte_vld_q <= byte_vld_d;
            frame_err  <= err_d;
            if (byte_vld_d) byte_q <= shift_q;
        end
    end

    c16_ps2_keymap u_keymap (
        .ext   (ext_q),
        .code  (byte_q),
        .entry (ent)
    );

    always_comb begin
        row_hit = '0;
        for (int j = 0; j < 8; j++) begin
            if (!col_sel_n[j]) row_hit = row_hit | matrix_q[j];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            matrix_q     <= '0;
            rel_q        <= 1'b0;
            ext_q        <= 1'b0;
            key_strobe   <= 1'b0;
            sysreset_req <= 1'b0;
            row_n        <= 8'hFF;
        end else begin
            key_strobe <= 1'b0;
            row_n      <= ~row_hit;
            if (frame_err) begin
                rel_q <= 1'b0;
                ext_q <= 1'b0;
            end else if (byte_vld_q) begin
                if (byte_q == SC_RELEASE) begin
                    rel_q <= 1'b1;
                end else if (byte_q == SC_EXT) begin
                    ext_q <= 1'b1;
                end else begin
                    rel_q <= 1'b0;
                    ext_q <= 1'b0;
                    // Strobe even when the bit does not change so typematic repeats are visible.
                    if (ent.valid) begin
                        matrix_q[ent.col][ent.row] <= ~rel_q;
                        key_strobe                 <= 1'b1;
                    end
                    if (!ext_q && byte_q == SC_F12) sysreset_req <= ~rel_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_c16_ps2_keymatrix.sv
module tb_c16_ps2_keymatrix;

    localparam int HALF = 15;
    localparam int GAP  = 40;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] col_sel_n;
    logic [7:0] row_n;
    logic       key_strobe;
    logic       sysreset_req;
    logic       frame_err;

    typedef struct packed {
        logic       err;
        logic [7:0] row;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    c16_ps2_keymatrix #(
        .CLK_HZ     (1000000),
        .FILTER_LEN (8),
        .TIMEOUT_US (200)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ps2_clk      (ps2_clk),
        .ps2_dat      (ps2_dat),
        .col_sel_n    (col_sel_n),
        .row_n        (row_n),
        .key_strobe   (key_strobe),
        .sysreset_req (sysreset_req),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic push_key(input logic [7:0] row);
        ev_t e;
        e.err = 1'b0;
        e.row = row;
        exp_q.push_back(e);
    endtask

    task automatic push_err();
        ev_t e;
        e.err = 1'b1;
        e.row = 8'h00;
        exp_q.push_back(e);
    endtask

    // Device-side frame: data changes while the clock is high, host samples on the fall.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = fr[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 11);
    endtask

    task automatic drain(input string nm);
        repeat (20) @(negedge clk);
        chk(nm, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every strobe/error pops one expectation; strobes also check row_n a cycle later.
    initial begin
        ev_t ev;
        forever begin
            @(negedge clk);
            if (reset_n !== 1'b1) continue;
            if (key_strobe || frame_err) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: strobe=%0b err=%0b expected none (t=%0t)",
                             key_strobe, frame_err, $time);
                end else begin
                    ev = exp_q.pop_front();
                    chk("event_kind", 32'({key_strobe, frame_err}), ev.err ? 32'd1 : 32'd2);
                    if (!ev.err) begin
                        @(negedge clk);
                        chk("row_after_strobe", 32'(row_n), 32'(ev.row));
                    end
                end
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        ps2_clk   = 1'b1;
        ps2_dat   = 1'b1;
        col_sel_n = 8'hFF;
        repeat (4) @(negedge clk);
        chk("reset_row_n", 32'(row_n), 32'hFF);
        chk("reset_strobe", 32'(key_strobe), 32'd0);
        chk("reset_sysreset", 32'(sysreset_req), 32'd0);
        chk("reset_frame_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Make/typematic/break A on column 1.
        col_sel_n = 8'hFD;
        push_key(8'hFB); send(8'h1C);
        push_key(8'hFB); send(8'h1C);
        send(8'hF0);
        push_key(8'hFF); send(8'h1C);
        drain("t1_queue");

        // Return + A across columns 0 and 1, then column select variations.
        col_sel_n = 8'hFC;
        push_key(8'hFD); send(8'h5A);
        push_key(8'hF9); send(8'h1C);
        drain("t2_queue");
        col_sel_n = 8'hFE;
        repeat (2) @(negedge clk);
        chk("col0_only", 32'(row_n), 32'hFD);
        col_sel_n = 8'hFF;
        repeat (2) @(negedge clk);
        chk("no_col_sel", 32'(row_n), 32'hFF);
        col_sel_n = 8'hFC;
        send(8'hF0); push_key(8'hFB); send(8'h5A);
        send(8'hF0); push_key(8'hFF); send(8'h1C);
        drain("t2_release_queue");

        // Shift and A share column 1.
        col_sel_n = 8'hFD;
        push_key(8'h7F); send(8'h12);
        push_key(8'h7B); send(8'h1C);
        send(8'hF0); push_key(8'hFB); send(8'h12);
        send(8'hF0); push_key(8'hFF); send(8'h1C);
        drain("t_shift_queue");

        // Space on column 7.
        col_sel_n = 8'h7F;
        push_key(8'hEF); send(8'h29);
        send(8'hF0); push_key(8'hFF); send(8'h29);
        drain("t_space_queue");

        // Bad parity leaves the matrix alone; following F0 1C still releases.
        col_sel_n = 8'hFD;
        push_key(8'hFB); send(8'h1C);
        push_err(); send_frame(8'h1C, 1'b1, 1'b0, 11);
        drain("t3_parity_queue");
        chk("row_after_parity_err", 32'(row_n), 32'hFB);
        send(8'hF0); push_key(8'hFF); send(8'h1C);
        push_err(); send_frame(8'h1C, 1'b0, 1'b1, 11);
        drain("t3_stop_queue");
        chk("row_after_stop_err", 32'(row_n), 32'hFF);

        // Mid-frame stall triggers timeout; next frame decodes normally.
        push_err(); send_frame(8'h33, 1'b0, 1'b0, 5);
        repeat (250) @(negedge clk);
        drain("t4_timeout_queue");
        col_sel_n = 8'hFE;
        push_key(8'hFD); send(8'h5A);
        send(8'hF0); push_key(8'hFF); send(8'h5A);
        drain("t4_after_queue");

        // E0 1C is unmapped; plain 1C afterwards proves ext was cleared.
        col_sel_n = 8'hFD;
        send(8'hE0); send(8'h1C);
        drain("t5_unmapped_queue");
        chk("row_after_unmapped", 32'(row_n), 32'hFF);
        push_key(8'hFB); send(8'h1C);
        send(8'hF0); push_key(8'hFF); send(8'h1C);
        drain("t5_plain_queue");

        // Extended cursor-down with E0 F0 release.
        col_sel_n = 8'hDF;
        send(8'hE0); push_key(8'hFE); send(8'h72);
        send(8'hE0); send(8'hF0); push_key(8'hFF); send(8'h72);
        drain("t_ext_queue");

        // F12 level request.
        col_sel_n = 8'hFD;
        send(8'h07);
        drain("t6_f12_queue");
        chk("f12_make", 32'(sysreset_req), 32'd1);
        send(8'hF0); send(8'h07);
        drain("t6_f12_rel_queue");
        chk("f12_break", 32'(sysreset_req), 32'd0);

        // Reset mid-frame with A and F12 held.
        send(8'h07);
        push_key(8'hFB); send(8'h1C);
        drain("t6_pre_reset_queue");
        chk("pre_reset_sysreset", 32'(sysreset_req), 32'd1);
        send_frame(8'h5A, 1'b0, 1'b0, 3);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midreset_row_n", 32'(row_n), 32'hFF);
        chk("midreset_strobe", 32'(key_strobe), 32'd0);
        chk("midreset_sysreset", 32'(sysreset_req), 32'd0);
        chk("midreset_frame_err", 32'(frame_err), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("matrix_cleared", 32'(row_n), 32'hFF);
        repeat (250) @(negedge clk);
        push_key(8'hFB); send(8'h1C);
        drain("post_reset_queue");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
